fb_write_sched: RTL and testbench
=================================

// Module: fb_write_sched
// PURPOSE
//  Shares the framebuffer write port (X/Y/pixel/wr_en) among NREQ pixel producers with round-robin arbitration.
//  Sequences a hardware full-screen clear, replacing the "hold srst for width*height cycles" clear method.
//  Optional tear-free gating restricts producer writes to blanking. Sits between producers and the VGA scan-out block, on vclk.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  COORD_W 10   coordinate width
//  PIX_W    3   pixel colour width
// PORTS
//  vclk         in   1            video clock, all logic on rising edge
//  srst         in   1            synchronous reset, active-high
//  width        in   COORD_W      active width in pixels
//  height       in   COORD_W      active height in lines
//  visible      in   1            from scan-out; 1 = active video
//  tearfree     in   1            1 = producer writes only while visible==0
//  clear_start  in   1            1-cycle pulse: start full-screen clear
//  clear_color  in   PIX_W        colour used by clear
//  clear_busy   out  1            clear sweep in progress
//  req_valid    in   NREQ         per-requester write valid
//  req_x        in   NREQ*COORD_W packed, requester i at [i*COORD_W +: COORD_W]
//  req_y        in   NREQ*COORD_W packed, same layout
//  req_pixel    in   NREQ*PIX_W   packed, same layout
//  req_ready    out  NREQ         one-hot accept; handshake = valid & ready
//  fb_x, fb_y   out  COORD_W      write address to framebuffer
//  fb_pixel     out  PIX_W        write data
//  fb_wr_en     out  1            write strobe
//  drop         out  1            1-cycle pulse: out-of-range write discarded (see CONFIGURATION)
// BEHAVIOUR
//  Reset: fb_wr_en=0, fb_x=fb_y=0, fb_pixel=0, req_ready=0, clear_busy=0, drop=0, rr pointer=0, state IDLE.
//  FSM IDLE/CLEAR. In IDLE, clear_start has priority over requests. No grant is issued in the clear_start cycle.
//  IDLE->CLEAR on clear_start, only when width!=0 && height!=0; otherwise clear_start is ignored.
//  In CLEAR, clear_start is ignored.
//  Entering CLEAR latches width, height and clear_color. Later changes to them do not affect the sweep in progress.
//  CLEAR sweeps raster order x 0..W-1 inside y 0..H-1, one write per cycle, fb_wr_en=1. Exactly W*H writes.
//  clear_busy=1 from the first sweep cycle through the last write cycle. Returns to IDLE after the last write.
//  CLEAR ignores tearfree. req_ready=0 throughout CLEAR.
//  Arbitration in IDLE: eligible = req_valid & {NREQ{!tearfree | !visible}}.
//  Winner = first eligible index searching upward from ptr, with wrap-around.
//  req_ready is combinational: one-hot at the winner, 0 if none eligible. ready may depend on valid; valid must not depend on ready.
//  Producers hold valid and payload stable until accepted.
//  On accept: fb_x/fb_y/fb_pixel register the winner's payload. fb_wr_en=1 on the next cycle (latency 1).
//  On accept, ptr <= (winner+1) mod NREQ. Throughput is 1 write per cycle.
//  With no accept, fb_wr_en=0 next cycle and fb_x/fb_y/fb_pixel hold their values.
//  Tear-free skew: a write accepted in the last blanking cycle lands one cycle later. This is accepted behaviour.
//  srst at any time, including mid-clear, aborts next edge: reset values restored and no further writes.
// CONFIGURATION
//  Macro FB_WRITE_BOUNDS_CHECK_EN.
//  Defined: an accepted request with x>=width or y>=height is consumed (ready asserted normally).
//    Next cycle fb_wr_en=0, drop=1 for 1 cycle. ptr still advances.
//  Undefined: all accepted requests are forwarded unchanged, and drop is tied 0.
//  The drop port exists in both builds.
// STRUCTURE
//  Package fb_pkg: coord_t (COORD_W), pixel_t (PIX_W), enum sched_state_t {S_IDLE, S_CLEAR}, struct fb_wr_t {x, y, pixel}.
//  Sub-module fb_rr_arbiter: holds ptr register. Inputs: eligible, advance. Outputs: one-hot grant and index.
//  Clear counter and FSM stay in the top module.
// TESTING
//  1. Reset, width=4, height=3, clear_start, clear_color=5 -> 12 writes (0,0)..(3,2) raster, pixel=5, clear_busy high 12 cycles, no req_ready.
//  2. NREQ=4, all valid constantly, tearfree=0 -> grants 0,1,2,3,0,... one per cycle; fb_wr_en continuous after 1-cycle latency.
//  3. tearfree=1, req0 valid (x=10,y=20,pix=3), visible=1 for 5 cycles then 0 -> no ready while visible; accept on first blank cycle; fb write (10,20,3) next cycle.
//  4. clear_start in same cycle as req1 valid -> req1 not granted; clear runs to completion; req1 accepted on first IDLE cycle after.
//  5. srst asserted mid-clear (after 7 of 12 writes) -> next cycle fb_wr_en=0, clear_busy=0; no further writes.
//  6. Macro defined, width=640, req2 x=640 y=0 -> ready=1, fb_wr_en=0, drop=1 for 1 cycle. Macro undefined: write forwarded, drop=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types for the framebuffer write scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: default coordinate/pixel widths, scheduler state enum and the
// write-beat struct used to describe one framebuffer write.
package fb_pkg;

    localparam int FB_COORD_W = 10;
    localparam int FB_PIX_W   = 3;

    typedef logic [FB_COORD_W-1:0] coord_t;
    typedef logic [FB_PIX_W-1:0]   pixel_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } sched_state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        pixel_t pixel;
    } fb_wr_t;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or above the pointer, wrapping.
// Latency: grant/index combinational from eligible; pointer updates on the next vclk edge.
// Backpressure: none internally; advance_i moves the pointer past the current winner.
// Ports:
//   vclk, srst      clock and synchronous active-high reset (pointer -> 0)
//   eligible_i      per-requester eligibility, already gated by the caller
//   advance_i       1 = the current winner was accepted this cycle
//   grant_o         one-hot winner, 0 when nothing is eligible
//   idx_o           binary index of the winner (pointer value when none)
//   any_o           1 = some requester is eligible
module fb_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             vclk,
    input  logic             srst,
    input  logic [NREQ-1:0]  eligible_i,
    input  logic             advance_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Search upward from the pointer; the first hit wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        grant_o  = '0;
        idx_o    = ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && eligible_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
        any_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (int'(idx_o) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = IDX_W'(int'(idx_o) + 1);
            end
        end
    end

    always_ff @(posedge vclk) begin
        if (srst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: round-robin sharing among NREQ producers plus a hardware full-screen clear.
// Latency: 1 cycle from accept (valid & ready) to fb_wr_en; clear writes follow 1 cycle after each sweep step.
// Backpressure: req_ready is 0 during a clear, in the clear_start cycle, and (tearfree=1) during active video.
// Ports: vclk/srst (sync active-high); width/height active area; visible/tearfree gating;
//   clear_start/clear_color/clear_busy clear control; req_valid/req_x/req_y/req_pixel/req_ready
//   producer side (packed, requester i at [i*W +: W]); fb_x/fb_y/fb_pixel/fb_wr_en write port;
//   drop pulses when an out-of-range write is discarded.
// Build option: define FB_WRITE_BOUNDS_CHECK_EN to discard accepted writes with x>=width or y>=height;
//   without it every accepted write is forwarded and drop is tied 0.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int COORD_W = FB_COORD_W,
    parameter int PIX_W   = FB_PIX_W
) (
    input  logic                    vclk,
    input  logic                    srst,
    input  logic [COORD_W-1:0]      width,
    input  logic [COORD_W-1:0]      height,
    input  logic                    visible,
    input  logic                    tearfree,
    input  logic                    clear_start,
    input  logic [PIX_W-1:0]        clear_color,
    output logic                    clear_busy,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*COORD_W-1:0] req_x,
    input  logic [NREQ*COORD_W-1:0] req_y,
    input  logic [NREQ*PIX_W-1:0]   req_pixel,
    output logic [NREQ-1:0]         req_ready,
    output logic [COORD_W-1:0]      fb_x,
    output logic [COORD_W-1:0]      fb_y,
    output logic [PIX_W-1:0]        fb_pixel,
    output logic                    fb_wr_en,
    output logic                    drop
);

    localparam int IDX_W = $clog2(NREQ);

    sched_state_t       state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic [COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;
    logic [PIX_W-1:0]   fb_pix_q, fb_pix_d;
    logic               wr_en_q, wr_en_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [COORD_W-1:0] win_x, win_y;
    logic [PIX_W-1:0]   win_pix;
    logic               win_oob;

    // Grants only in IDLE and never in a clear_start cycle, so a clear always
    // wins over a same-cycle request.
    assign eligible = req_valid
                    & {NREQ{!tearfree || !visible}}
                    & {NREQ{(state_q == S_IDLE) && !clear_start}};

    fb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .vclk       (vclk),
        .srst       (srst),
        .eligible_i (eligible),
        .advance_i  (win_any),
        .grant_o    (grant),
        .idx_o      (win_idx),
        .any_o      (win_any)
    );

    assign req_ready = grant;

    assign win_x   = req_x[win_idx*COORD_W +: COORD_W];
    assign win_y   = req_y[win_idx*COORD_W +: COORD_W];
    assign win_pix = req_pixel[win_idx*PIX_W +: PIX_W];

`ifdef FB_WRITE_BOUNDS_CHECK_EN
    assign win_oob = (win_x >= width) || (win_y >= height);
`else
    assign win_oob = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        fb_x_d   = fb_x_q;
        fb_y_d   = fb_y_q;
        fb_pix_d = fb_pix_q;
        wr_en_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    // Zero-sized area: nothing to sweep, stay idle.
                    if ((width != '0) && (height != '0)) begin
                        state_d = S_CLEAR;
                        w_d     = width;
                        h_d     = height;
                        color_d = clear_color;
                        cx_d    = '0;
                        cy_d    = '0;
                    end
                end else if (win_any && !win_oob) begin
                    fb_x_d   = win_x;
                    fb_y_d   = win_y;
                    fb_pix_d = win_pix;
                    wr_en_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                // busy is registered alongside the write so it brackets exactly the W*H strobes.
                fb_x_d   = cx_q;
                fb_y_d   = cy_q;
                fb_pix_d = color_q;
                wr_en_d  = 1'b1;
                busy_d   = 1'b1;
                if (cx_q == w_q - COORD_W'(1)) begin
                    cx_d = '0;
                    if (cy_q == h_q - COORD_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + COORD_W'(1);
                    end
                end else begin
                    cx_d = cx_q + COORD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vclk) begin
        if (srst) begin
            state_q  <= S_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            fb_x_q   <= '0;
            fb_y_q   <= '0;
            fb_pix_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            w_q      <= w_d;
            h_q      <= h_d;
            color_q  <= color_d;
            fb_x_q   <= fb_x_d;
            fb_y_q   <= fb_y_d;
            fb_pix_q <= fb_pix_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
        end
    end

`ifdef FB_WRITE_BOUNDS_CHECK_EN
    logic drop_q;

    // The request is still consumed (ready was high); only the write is suppressed.
    always_ff @(posedge vclk) begin
        if (srst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= (state_q == S_IDLE) && !clear_start && win_any && win_oob;
        end
    end

    assign drop = drop_q;
`else
    assign drop = 1'b0;
`endif

    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_pixel   = fb_pix_q;
    assign fb_wr_en   = wr_en_q;
    assign clear_busy = busy_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed self-checking bench for fb_write_sched (NREQ=4, COORD_W=10, PIX_W=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expectations for the bounds-check build follow FB_WRITE_BOUNDS_CHECK_EN.
module tb_fb_write_sched;

    localparam int NREQ = 4;
    localparam int CW   = 10;
    localparam int PW   = 3;

    logic             vclk;
    logic             srst;
    logic [CW-1:0]    width;
    logic [CW-1:0]    height;
    logic             visible;
    logic             tearfree;
    logic             clear_start;
    logic [PW-1:0]    clear_color;
    logic             clear_busy;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*CW-1:0] req_x;
    logic [NREQ*CW-1:0] req_y;
    logic [NREQ*PW-1:0] req_pixel;
    logic [NREQ-1:0]  req_ready;
    logic [CW-1:0]    fb_x;
    logic [CW-1:0]    fb_y;
    logic [PW-1:0]    fb_pixel;
    logic             fb_wr_en;
    logic             drop;

    int n_assert = 0;
    int n_fail   = 0;

    fb_write_sched #(.NREQ(NREQ), .COORD_W(CW), .PIX_W(PW)) dut (
        .vclk        (vclk),
        .srst        (srst),
        .width       (width),
        .height      (height),
        .visible     (visible),
        .tearfree    (tearfree),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_pixel   (req_pixel),
        .req_ready   (req_ready),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_pixel    (fb_pixel),
        .fb_wr_en    (fb_wr_en),
        .drop        (drop)
    );

    initial vclk = 1'b0;
    always #5 vclk = ~vclk;

    task automatic tick();
        @(posedge vclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int x, input int y, input int p);
        chk({tag, "_wr_en"}, 32'(fb_wr_en), 32'd1);
        chk({tag, "_x"}, 32'(fb_x), x);
        chk({tag, "_y"}, 32'(fb_y), y);
        chk({tag, "_pix"}, 32'(fb_pixel), p);
    endtask

    task automatic set_req(input int i, input int x, input int y, input int p);
        req_x[i*CW +: CW]     = CW'(x);
        req_y[i*CW +: CW]     = CW'(y);
        req_pixel[i*PW +: PW] = PW'(p);
    endtask

    initial begin
        srst        = 1'b1;
        width       = '0;
        height      = '0;
        visible     = 1'b0;
        tearfree    = 1'b0;
        clear_start = 1'b0;
        clear_color = '0;
        req_valid   = '0;
        req_x       = '0;
        req_y       = '0;
        req_pixel   = '0;
        tick();
        tick();

        // Reset state
        chk("rst_wr_en", 32'(fb_wr_en), 0);
        chk("rst_x", 32'(fb_x), 0);
        chk("rst_y", 32'(fb_y), 0);
        chk("rst_pix", 32'(fb_pixel), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_drop", 32'(drop), 0);
        srst = 1'b0;
        tick();

        // 1: 4x3 clear with colour 5, raster order
        width       = 10'd4;
        height      = 10'd3;
        clear_color = 3'd5;
        clear_start = 1'b1;
        #1;
        chk("clr1_start_ready", 32'(req_ready), 0);
        tick();
        clear_start = 1'b0;
        chk("clr1_first_cycle_wr", 32'(fb_wr_en), 0);
        // Changing inputs mid-sweep must not disturb it.
        width       = 10'd9;
        clear_color = 3'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_wr("clr1", i % 4, i / 4, 5);
            chk("clr1_busy", 32'(clear_busy), 1);
            chk("clr1_ready", 32'(req_ready), 0);
        end
        tick();
        chk("clr1_end_wr", 32'(fb_wr_en), 0);
        chk("clr1_end_busy", 32'(clear_busy), 0);
        width = 10'd4;

        // 2: all four requesters valid, grants rotate 0,1,2,3,...
        for (int i = 0; i < NREQ; i++) set_req(i, i * 10 + 1, i * 10 + 2, i + 1);
        req_valid = 4'b1111;
        #1;
        chk("rr_ready0", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_wr("rr", (k % 4) * 10 + 1, (k % 4) * 10 + 2, (k % 4) + 1);
            chk("rr_ready", 32'(req_ready), 32'd1 << ((k + 1) % 4));
        end
        req_valid = '0;
        tick();
        chk("rr_idle_wr", 32'(fb_wr_en), 0);
        chk("rr_hold_x", 32'(fb_x), 31);
        chk("rr_hold_pix", 32'(fb_pixel), 4);

        // 3: tear-free gating holds the write until blanking
        tearfree  = 1'b1;
        visible   = 1'b1;
        set_req(0, 10, 20, 3);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("tf_ready_vis", 32'(req_ready), 0);
            tick();
            chk("tf_wr_vis", 32'(fb_wr_en), 0);
        end
        visible = 1'b0;
        #1;
        chk("tf_ready_blank", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk_wr("tf", 10, 20, 3);
        tearfree = 1'b0;
        tick();

        // 4: clear_start wins over a same-cycle request
        clear_color = 3'd2;
        set_req(1, 7, 8, 6);
        req_valid   = 4'b0010;
        clear_start = 1'b1;
        #1;
        chk("clr4_start_ready", 32'(req_ready), 0);
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("clr4_ready", 32'(req_ready), 0);
            tick();
            chk_wr("clr4", i % 4, i / 4, 2);
        end
        chk("clr4_ready_after", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk_wr("clr4_req1", 7, 8, 6);
        chk("clr4_busy_after", 32'(clear_busy), 0);
        tick();

        // 5: reset mid-clear after 7 writes
        clear_color = 3'd1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_wr("clr5", i % 4, i / 4, 1);
        end
        srst = 1'b1;
        tick();
        chk("srst_wr", 32'(fb_wr_en), 0);
        chk("srst_busy", 32'(clear_busy), 0);
        srst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("srst_after_wr", 32'(fb_wr_en), 0);
            chk("srst_after_busy", 32'(clear_busy), 0);
        end

        // 6: x == width on requester 2
        width     = 10'd640;
        height    = 10'd480;
        set_req(2, 640, 0, 4);
        req_valid = 4'b0100;
        #1;
        chk("oob_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
        chk("oob_wr", 32'(fb_wr_en), 0);
        chk("oob_drop", 32'(drop), 1);
`else
        chk_wr("oob_fwd", 640, 0, 4);
        chk("oob_drop", 32'(drop), 0);
`endif
        tick();
        chk("oob_drop_end", 32'(drop), 0);
        chk("oob_wr_end", 32'(fb_wr_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
